// File: rtl/sram_arbiter.sv
// sram_arbiter: two-requester arbiter for a shared single-port SRAM with
// round-robin fairness, bounded lock bursts and registered per-requester read data.
module sram_arbiter #(
  parameter int BITS         = 32,
  parameter int ADRESS_WIDTH = 5,
  parameter int MAX_BURST    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    m0_req,
  input  logic                    m0_we,
  input  logic                    m0_lock,
  input  logic [ADRESS_WIDTH-1:0] m0_addr,
  input  logic [BITS-1:0]         m0_wdata,
  input  logic [BITS-1:0]         m0_mask,
  output logic                    m0_gnt,
  output logic [BITS-1:0]         m0_rdata,
  output logic                    m0_rvalid,
  input  logic                    m1_req,
  input  logic                    m1_we,
  input  logic                    m1_lock,
  input  logic [ADRESS_WIDTH-1:0] m1_addr,
  input  logic [BITS-1:0]         m1_wdata,
  input  logic [BITS-1:0]         m1_mask,
  output logic                    m1_gnt,
  output logic [BITS-1:0]         m1_rdata,
  output logic                    m1_rvalid,
  output logic                    sram_cen,
  output logic                    sram_wen,
  output logic [ADRESS_WIDTH-1:0] sram_adress,
  output logic [BITS-1:0]         sram_din,
  output logic [BITS-1:0]         sram_mask,
  input  logic [BITS-1:0]         sram_dout
);
  logic            last_q, last_d, lock_q, lock_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            rv0_q, rv0_d, rv1_q, rv1_d;
  logic [BITS-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
  logic            any, sel, locked;
  logic [1:0]      req;
  assign req = {m1_req, m0_req};
  // lock_q is only set when the previous cycle granted last_q with its lock high
  always_comb begin
    locked      = lock_q && (cnt_q < 4'(MAX_BURST)) && req[last_q];
    any         = rst_n && (|req);
    sel         = locked ? last_q : (&req ? ~last_q : m1_req);
    m0_gnt      = any && !sel;
    m1_gnt      = any && sel;
    sram_cen    = any;
    sram_wen    = any && (sel ? m1_we : m0_we);
    sram_adress = any ? (sel ? m1_addr : m0_addr) : '0;
    sram_din    = any ? (sel ? m1_wdata : m0_wdata) : '0;
    sram_mask   = any ? (sel ? m1_mask : m0_mask) : '1;
    last_d      = any ? sel : last_q;
    lock_d      = any && (sel ? m1_lock : m0_lock);
    cnt_d       = !any ? 4'd0 : (sel != last_q) ? 4'd1 : (&cnt_q) ? cnt_q : cnt_q + 4'd1;
    rv0_d       = m0_gnt && !m0_we;
    rv1_d       = m1_gnt && !m1_we;
    rd0_d       = rv0_d ? sram_dout : rd0_q;
    rd1_d       = rv1_d ? sram_dout : rd1_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
      lock_q <= 1'b0;
      cnt_q  <= '0;
      rv0_q  <= 1'b0;
      rv1_q  <= 1'b0;
      rd0_q  <= '0;
      rd1_q  <= '0;
    end else begin
      last_q <= last_d;
      lock_q <= lock_d;
      cnt_q  <= cnt_d;
      rv0_q  <= rv0_d;
      rv1_q  <= rv1_d;
      rd0_q  <= rd0_d;
      rd1_q  <= rd1_d;
    end
  end
  assign m0_rvalid = rv0_q;
  assign m1_rvalid = rv1_q;
  assign m0_rdata  = rd0_q;
  assign m1_rdata  = rd1_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: vector table of per-cycle requests and expected grants, with
// a reference memory feeding a read-data scoreboard.
module tb_sram_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [4:0] m0_addr, m1_addr, sram_adress;
  logic [31:0] m0_wdata, m0_mask, m1_wdata, m1_mask, m0_rdata, m1_rdata;
  logic [31:0] sram_din, sram_mask, sram_dout;
  logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, sram_cen, sram_wen;
  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  logic [31:0] last_rd0 = '0, last_rd1 = '0;
  int tests = 0, fails = 0;

  typedef struct {
    logic [1:0]  req, we, lock;
    logic [4:0]  a0, a1;
    logic [31:0] wd, wm;
    logic [1:0]  eg;
  } vec_t;
  typedef struct {
    logic        who;
    logic [31:0] data;
  } sb_t;
  vec_t vecs[$];
  sb_t  sbq[$];

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_mask(m0_mask), .m0_gnt(m0_gnt), .m0_rdata(m0_rdata),
    .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_mask(m1_mask), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
    .m1_rvalid(m1_rvalid),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_adress(sram_adress),
    .sram_din(sram_din), .sram_mask(sram_mask), .sram_dout(sram_dout)
  );

  assign sram_dout = (sram_cen && !sram_wen) ? mem[sram_adress] : '0;
  always @(posedge clk)
    if (sram_cen && sram_wen)
      mem[sram_adress] <= (mem[sram_adress] & sram_mask) | (sram_din & ~sram_mask);

  task automatic chk(input string n, input logic [70:0] act, input logic [70:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] req, we, lock, input logic [4:0] a0, a1,
                              input logic [31:0] wd, wm, input logic [1:0] eg);
    vec_t v;
    v.req = req; v.we = we; v.lock = lock; v.a0 = a0; v.a1 = a1;
    v.wd = wd; v.wm = wm; v.eg = eg;
    return v;
  endfunction

  function automatic logic [70:0] exp_bus(input vec_t v);
    int k;
    if (v.eg == 2'b00) return {1'b0, 1'b0, 5'd0, 32'd0, 32'hFFFF_FFFF};
    k = v.eg[1] ? 1 : 0;
    return {1'b1, v.we[k], (k == 1) ? v.a1 : v.a0, v.wd, v.wm};
  endfunction

  task automatic drive(input vec_t v);
    {m1_req, m0_req} = v.req;
    {m1_we, m0_we} = v.we;
    {m1_lock, m0_lock} = v.lock;
    m0_addr = v.a0; m1_addr = v.a1;
    m0_wdata = v.wd; m1_wdata = v.wd;
    m0_mask = v.wm; m1_mask = v.wm;
  endtask

  task automatic drive_check(input vec_t v);
    drive(v);
    #1;
    chk("gnt", {m1_gnt, m0_gnt}, v.eg);
    chk("sram_bus", {sram_cen, sram_wen, sram_adress, sram_din, sram_mask}, exp_bus(v));
  endtask

  task automatic edge_update(input vec_t v);
    int k;
    logic [4:0] a;
    logic [1:0] exp_rv;
    sb_t e;
    @(posedge clk);
    if (v.eg != 2'b00) begin
      k = v.eg[1] ? 1 : 0;
      a = (k == 1) ? v.a1 : v.a0;
      if (v.we[k]) ref_mem[a] = (ref_mem[a] & v.wm) | (v.wd & ~v.wm);
      else sbq.push_back('{who: (k == 1), data: ref_mem[a]});
    end
    #1;
    exp_rv = 2'b00;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      exp_rv[e.who] = 1'b1;
      if (e.who) last_rd1 = e.data;
      else last_rd0 = e.data;
    end
    chk("rvalid", {m1_rvalid, m0_rvalid}, exp_rv);
    chk("m0_rdata", m0_rdata, last_rd0);
    chk("m1_rdata", m1_rdata, last_rd1);
    @(negedge clk);
  endtask

  task automatic run(input vec_t v);
    drive_check(v);
    edge_update(v);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] = (i == 5) ? 32'd0 : (32'hC0DE_0000 | i);
      ref_mem[i] = mem[i];
    end
    // {m1,m0} encoding for req/we/lock and expected grants
    vecs.push_back(mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(2'b11, 2'b00, 2'b00, 3, 7, 0, 0, 2'b01));
    vecs.push_back(mk(2'b10, 2'b00, 2'b00, 3, 7, 0, 0, 2'b10));
    vecs.push_back(mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(2'b01, 2'b01, 2'b00, 5, 0, 32'hFFFF_FFFF, 32'hFFFF_0000, 2'b01));
    vecs.push_back(mk(2'b01, 2'b00, 2'b00, 5, 0, 0, 0, 2'b01));
    vecs.push_back(mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(2'b10, 2'b00, 2'b00, 0, 1, 0, 0, 2'b10));
    vecs.push_back(mk(2'b11, 2'b00, 2'b01, 8, 9, 0, 0, 2'b01));
    vecs.push_back(mk(2'b11, 2'b00, 2'b01, 10, 9, 0, 0, 2'b01));
    vecs.push_back(mk(2'b11, 2'b00, 2'b01, 11, 9, 0, 0, 2'b01));
    vecs.push_back(mk(2'b11, 2'b00, 2'b01, 12, 9, 0, 0, 2'b01));
    vecs.push_back(mk(2'b11, 2'b00, 2'b01, 13, 9, 0, 0, 2'b10));
    vecs.push_back(mk(2'b11, 2'b00, 2'b01, 13, 14, 0, 0, 2'b01));
    vecs.push_back(mk(2'b11, 2'b00, 2'b01, 15, 14, 0, 0, 2'b01));
    vecs.push_back(mk(2'b10, 2'b00, 2'b00, 0, 14, 0, 0, 2'b10));
    vecs.push_back(mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(2'b01, 2'b00, 2'b00, 7, 0, 0, 0, 2'b01));
    vecs.push_back(mk(2'b10, 2'b10, 2'b00, 0, 7, 32'h1234_5678, 32'h0, 2'b10));
    vecs.push_back(mk(2'b01, 2'b00, 2'b00, 7, 0, 0, 0, 2'b01));
    vecs.push_back(mk(2'b10, 2'b10, 2'b00, 0, 7, 32'h0, 32'hFFFF_FFFF, 2'b10));
    vecs.push_back(mk(2'b10, 2'b00, 2'b00, 0, 7, 0, 0, 2'b10));
    for (int i = 0; i < 10; i++) vecs.push_back(mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00));

    drive(mk(2'b11, 2'b00, 2'b00, 3, 7, 0, 0, 2'b00));
    #1;
    chk("reset_gnt", {m1_gnt, m0_gnt}, 2'b00);
    chk("reset_bus", {sram_cen, sram_wen, sram_adress, sram_din, sram_mask},
        {1'b0, 1'b0, 5'd0, 32'd0, 32'hFFFF_FFFF});
    @(posedge clk); #1;
    chk("reset_regs", {m1_rvalid, m0_rvalid, m1_rdata, m0_rdata}, 66'd0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) run(vecs[i]);

    // read granted to m0 (last_gnt becomes 0), then reset hits before its data is seen
    drive_check(mk(2'b01, 2'b00, 2'b00, 3, 0, 0, 0, 2'b01));
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00));
    #1;
    chk("midrd_rst", {m1_rvalid, m0_rvalid, m1_rdata, m0_rdata, sram_cen}, 67'd0);
    last_rd0 = '0; last_rd1 = '0;
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run(mk(2'b11, 2'b00, 2'b00, 3, 7, 0, 0, 2'b01));
    run(mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
